memory_cycle: RTL and testbench
===============================

# memory_cycle

Memory stage of the 18-bit five-stage pipeline: it takes the execute-stage result, performs the data-memory load or store over a variable-latency request/acknowledge port, and registers the MEM/WB pipeline register that feeds the writeback stage. A watchdog counter bounds each access. The stage also drives the stall signal that freezes the upstream stages while an access is outstanding.

## Interface
- `WIDTH`, default 18: datapath width.
- `RA_W`, default 4: destination register address width.
- `TIMEOUT`, default 15: maximum wait cycles before an access is abandoned (1..255).
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RegWriteM`  in  1  register-file write enable from execute.
- `ResultSrcM`  in  2  result select: 00 ALU, 01 load data, 10 PC+4; 11 is treated as 00.
- `MemWriteM`  in  1  store request.
- `RdM`  in  RA_W  destination register.
- `ALU_ResultM`  in  WIDTH  ALU result; also the memory address.
- `WriteDataM`  in  WIDTH  store data.
- `PCPlus4M`  in  WIDTH  PC+4 of the instruction.
- `mem_req`  out  1  access request.
- `mem_we`  out  1  1 = store, 0 = load.
- `mem_addr`  out  WIDTH  access address.
- `mem_wdata`  out  WIDTH  store data.
- `mem_rdata`  in  WIDTH  load data, valid when `mem_ack`=1.
- `mem_ack`  in  1  access complete (one-cycle pulse).
- `StallM`  out  1  freeze fetch/decode/execute this cycle.
- `mem_err`  out  1  sticky timeout flag.
- `RegWriteW`, `ResultSrcW[1:0]`, `RdW[RA_W-1:0]`, `ALU_ResultW`, `ReadDataW`, `PCPlus4W`  out  MEM/WB register outputs to writeback.

## Operation
- memop = MemWriteM | (ResultSrcM==01). If both are set, the store wins and RegWriteW is forced to 0.
- `mem_addr` = ALU_ResultM, `mem_wdata` = WriteDataM, `mem_we` = MemWriteM. All three are combinational.
- FSM states are IDLE, WAIT and DONE.
  - IDLE: `mem_req` = memop. If memop and `mem_ack`, the access completes in the same cycle and the state stays IDLE. If memop and no ack, go to WAIT and clear the wait counter.
  - WAIT: `mem_req`=1. The wait counter increments each cycle.
    - On `mem_ack`, latch `mem_rdata` and go to IDLE (completion).
    - When the counter reaches TIMEOUT-1 without an ack, set `mem_err`, complete with ReadData=0, and go to DONE.
  - DONE: `mem_req`=0 and `mem_ack` is ignored. Go to IDLE after one cycle. This cycle gives memory one clean gap before the next request.
- StallM = (memop & ~completion & state≠DONE) | (state==DONE). StallM is combinational.
- MEM/WB register behaviour:
  - If StallM=0, it loads the M-side fields. ReadDataW gets `mem_rdata` on a same-cycle ack, otherwise the latched/abandoned value.
  - If StallM=1, it loads a bubble: RegWriteW=0, other fields hold.
- A non-memory instruction never stalls and never asserts `mem_req`.
- `mem_ack` in IDLE without memop is ignored.
- `mem_err` clears only on reset.

## Timing
- Reset (async, `rst`=0) drives all of the following to 0: state IDLE, wait counter, `mem_err`, RegWriteW, ResultSrcW, RdW, ALU_ResultW, ReadDataW, PCPlus4W. `mem_req` is 0 while in reset.
- Reset in the middle of WAIT abandons the access immediately. A late `mem_ack` after reset release, with no memop, is ignored.
- Zero-wait access (ack in the request cycle): no stall. The W outputs update at the next edge (latency 1).
- Ack after N≥1 extra cycles: StallM is high for N cycles and the instruction reaches W on the edge after the ack.
- Timeout: StallM is high for TIMEOUT cycles plus 1 DONE cycle. `mem_err` rises on the edge that leaves WAIT.
- The wait counter is 8 bits and saturates; it never wraps.

## Test plan
- ALU op: ResultSrcM=00, RdM=3, ALU_ResultM=0x00123, RegWriteM=1 → no `mem_req`, StallM=0. Next cycle RegWriteW=1, RdW=3, ALU_ResultW=0x00123.
- Zero-wait load: ResultSrcM=01, address 0x00040, ack same cycle with rdata 0x2ABCD → StallM=0, `mem_req`=1 for 1 cycle. Next cycle ReadDataW=0x2ABCD, ResultSrcW=01.
- Store with 3-cycle latency: MemWriteM=1, address 0x00010, data 0x3FFFF, ack on the 4th cycle → `mem_we`=1, StallM high for 3 cycles, RegWriteW=0 through the stall. The instruction reaches W with RegWriteW=0.
- Timeout: load with no ack, TIMEOUT=15 → StallM high for 16 cycles, `mem_err`=1, ReadDataW=0. A subsequent ALU op proceeds normally and `mem_err` stays 1.
- Reset mid-WAIT: assert `rst`=0 two cycles into a load → all outputs 0 at once. After release with an idle pipeline, a stray `mem_ack` has no effect and `mem_req`=0.
- Back-to-back loads, each acked in the same cycle → no stalls, and the W outputs carry each loaded value on consecutive cycles.

Source files
------------

// File: rtl/memory_cycle.sv
// Memory stage of the 18-bit pipeline: performs the data-memory access over a
// req/ack port with a watchdog, drives the upstream stall and the MEM/WB register.
module memory_cycle #(
    parameter int WIDTH   = 18,
    parameter int RA_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RegWriteM,
    input  logic [1:0]       ResultSrcM,
    input  logic             MemWriteM,
    input  logic [RA_W-1:0]  RdM,
    input  logic [WIDTH-1:0] ALU_ResultM,
    input  logic [WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0] PCPlus4M,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             StallM,
    output logic             mem_err,
    output logic             RegWriteW,
    output logic [1:0]       ResultSrcW,
    output logic [RA_W-1:0]  RdW,
    output logic [WIDTH-1:0] ALU_ResultW,
    output logic [WIDTH-1:0] ReadDataW,
    output logic [WIDTH-1:0] PCPlus4W,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t           state;
    logic [7:0]       wait_cnt;
    logic [WIDTH-1:0] rdata_q;

    logic             is_load;
    logic             memop;
    logic             ack_done;
    logic             timeout_hit;
    logic             completion;
    logic [WIDTH-1:0] read_data;

    assign mem_addr  = ALU_ResultM;
    assign mem_wdata = WriteDataM;
    assign mem_we    = MemWriteM;
    assign dbg_state = state;

    always_comb begin
        is_load     = (ResultSrcM == 2'b01);
        memop       = MemWriteM | is_load;
        ack_done    = ((state == IDLE) && memop && mem_ack) || ((state == WAIT) && mem_ack);
        timeout_hit = (state == WAIT) && !mem_ack && (wait_cnt >= LAST_CNT);
        completion  = ack_done | timeout_hit;
        StallM      = (memop & ~completion & (state != DONE)) | (state == DONE);
        // Request is masked during reset so memory never sees a request from a held stage.
        mem_req     = rst & ((state == WAIT) | ((state == IDLE) & memop));
        if (ack_done) begin
            read_data = mem_rdata;
        end else if (timeout_hit) begin
            read_data = '0;
        end else begin
            read_data = rdata_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            mem_err     <= 1'b0;
            rdata_q     <= '0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RdW         <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
            PCPlus4W    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memop && !mem_ack) begin
                        state    <= WAIT;
                        wait_cnt <= '0;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        state <= IDLE;
                    end else if (timeout_hit) begin
                        state   <= DONE;
                        mem_err <= 1'b1;
                    end else if (wait_cnt != 8'hFF) begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (!StallM) begin
                // A store that also claims load data wins; it must not write the register file.
                RegWriteW   <= RegWriteM & ~(MemWriteM & is_load);
                ResultSrcW  <= (ResultSrcM == 2'b11) ? 2'b00 : ResultSrcM;
                RdW         <= RdM;
                ALU_ResultW <= ALU_ResultM;
                ReadDataW   <= read_data;
                PCPlus4W    <= PCPlus4M;
                rdata_q     <= read_data;
            end else begin
                RegWriteW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: ALU op, zero-wait and delayed accesses,
// timeout, store/load conflict, reset mid-access and back-to-back loads.
module tb_memory_cycle;

    localparam int W  = 18;
    localparam int RA = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          RegWriteM = 1'b0;
    logic [1:0]    ResultSrcM = 2'b00;
    logic          MemWriteM = 1'b0;
    logic [RA-1:0] RdM = '0;
    logic [W-1:0]  ALU_ResultM = '0;
    logic [W-1:0]  WriteDataM = '0;
    logic [W-1:0]  PCPlus4M = '0;
    logic          mem_req;
    logic          mem_we;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata = '0;
    logic          mem_ack = 1'b0;
    logic          StallM;
    logic          mem_err;
    logic          RegWriteW;
    logic [1:0]    ResultSrcW;
    logic [RA-1:0] RdW;
    logic [W-1:0]  ALU_ResultW;
    logic [W-1:0]  ReadDataW;
    logic [W-1:0]  PCPlus4W;
    logic [1:0]    dbg_state;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    memory_cycle #(.WIDTH(W), .RA_W(RA), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
        .RdM(RdM), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .StallM(StallM), .mem_err(mem_err),
        .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW), .RdW(RdW),
        .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
        .dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one instruction and holds it until the stage stops stalling.
    // ack_at = cycle index (0 = request cycle) carrying mem_ack, -1 = never.
    task automatic issue(input logic regw, input logic [1:0] rsrc, input logic memw,
                         input logic [RA-1:0] rd, input logic [W-1:0] alu,
                         input logic [W-1:0] wd, input logic [W-1:0] pc,
                         input int ack_at, input logic [W-1:0] rdata,
                         output int stalls, output logic req0, output logic we0,
                         output int wr_in_stall);
        logic s;
        logic done;
        RegWriteM   = regw;
        ResultSrcM  = rsrc;
        MemWriteM   = memw;
        RdM         = rd;
        ALU_ResultM = alu;
        WriteDataM  = wd;
        PCPlus4M    = pc;
        stalls      = 0;
        wr_in_stall = 0;
        done        = 1'b0;
        req0        = 1'b0;
        we0         = 1'b0;
        for (int c = 0; c < 64; c++) begin
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rdata : '0;
            @(negedge clk);
            s = StallM;
            if (c == 0) begin
                req0 = mem_req;
                we0  = mem_we;
            end
            if (s) stalls++;
            @(posedge clk);
            #1;
            mem_ack   = 1'b0;
            mem_rdata = '0;
            if (!s) begin
                done = 1'b1;
                break;
            end
            if (RegWriteW) wr_in_stall++;
        end
        if (!done) check("stall_bound", 32'd1, 32'd0);
    endtask

    int   st;
    logic rq;
    logic we;
    int   wr;

    initial begin
        // Reset, with a load presented to confirm the request is masked.
        ResultSrcM = 2'b01;
        @(negedge clk);
        @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_regwrite", RegWriteW, 0);
        check("rst_alu", ALU_ResultW, 0);
        check("rst_rdata", ReadDataW, 0);
        check("rst_err", mem_err, 0);
        check("rst_state", dbg_state, 0);
        ResultSrcM = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // ALU op
        issue(1'b1, 2'b00, 1'b0, 4'd3, 18'h00123, 18'h0, 18'h00004, -1, 18'h0, st, rq, we, wr);
        check("alu_stall", st, 0);
        check("alu_req", rq, 0);
        check("alu_regwrite", RegWriteW, 1);
        check("alu_rd", RdW, 3);
        check("alu_result", ALU_ResultW, 18'h00123);
        check("alu_src", ResultSrcW, 0);
        check("alu_pc", PCPlus4W, 18'h00004);

        // Zero-wait load
        issue(1'b1, 2'b01, 1'b0, 4'd5, 18'h00040, 18'h0, 18'h00008, 0, 18'h2ABCD, st, rq, we, wr);
        check("zw_stall", st, 0);
        check("zw_req", rq, 1);
        check("zw_we", we, 0);
        check("zw_rdata", ReadDataW, 18'h2ABCD);
        check("zw_src", ResultSrcW, 1);
        check("zw_rd", RdW, 5);

        // Store acked on the 4th cycle
        issue(1'b0, 2'b00, 1'b1, 4'd0, 18'h00010, 18'h3FFFF, 18'h0000C, 3, 18'h0, st, rq, we, wr);
        check("st_stall", st, 3);
        check("st_we", we, 1);
        check("st_req", rq, 1);
        check("st_bubble", wr, 0);
        check("st_regwrite", RegWriteW, 0);
        check("st_addr_w", ALU_ResultW, 18'h00010);
        check("st_state", dbg_state, 0);

        // Store with load select: store wins, no register write
        issue(1'b1, 2'b01, 1'b1, 4'd4, 18'h00020, 18'h00777, 18'h00010, 0, 18'h12345, st, rq, we, wr);
        check("sw_stall", st, 0);
        check("sw_we", we, 1);
        check("sw_regwrite", RegWriteW, 0);

        // Load that never gets acked
        issue(1'b1, 2'b01, 1'b0, 4'd7, 18'h00055, 18'h0, 18'h00058, -1, 18'h0, st, rq, we, wr);
        check("to_stall_wait", st, 15);
        check("to_err", mem_err, 1);
        check("to_rdata", ReadDataW, 0);
        check("to_regwrite", RegWriteW, 1);
        check("to_rd", RdW, 7);
        check("to_state", dbg_state, 2);

        // Next ALU op sees the DONE gap; an ack there is ignored
        issue(1'b1, 2'b00, 1'b0, 4'd9, 18'h002AA, 18'h0, 18'h00060, 0, 18'h3FFFF, st, rq, we, wr);
        check("post_to_stall", st, 1);
        check("post_to_req", rq, 0);
        check("post_to_alu", ALU_ResultW, 18'h002AA);
        check("post_to_rd", RdW, 9);
        check("post_to_rdata", ReadDataW, 0);
        check("post_to_err", mem_err, 1);

        // Reset two cycles into a load
        RegWriteM   = 1'b1;
        ResultSrcM  = 2'b01;
        MemWriteM   = 1'b0;
        RdM         = 4'd6;
        ALU_ResultM = 18'h00077;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_state", dbg_state, 1);
        rst = 1'b0;
        #1;
        check("mr_req", mem_req, 0);
        check("mr_state", dbg_state, 0);
        check("mr_err", mem_err, 0);
        check("mr_regwrite", RegWriteW, 0);
        check("mr_alu", ALU_ResultW, 0);
        check("mr_rd", RdW, 0);
        check("mr_pc", PCPlus4W, 0);
        RegWriteM   = 1'b0;
        ResultSrcM  = 2'b00;
        RdM         = '0;
        ALU_ResultM = '0;
        @(negedge clk);
        rst = 1'b1;
        issue(1'b0, 2'b00, 1'b0, 4'd0, 18'h0, 18'h0, 18'h0, 0, 18'h1F1F1, st, rq, we, wr);
        check("stray_req", rq, 0);
        check("stray_stall", st, 0);
        check("stray_rdata", ReadDataW, 0);
        check("stray_state", dbg_state, 0);

        // Back-to-back zero-wait loads
        issue(1'b1, 2'b01, 1'b0, 4'd1, 18'h00100, 18'h0, 18'h00104, 0, 18'h15555, st, rq, we, wr);
        check("b2b1_stall", st, 0);
        check("b2b1_rdata", ReadDataW, 18'h15555);
        check("b2b1_rd", RdW, 1);
        issue(1'b1, 2'b01, 1'b0, 4'd2, 18'h00101, 18'h0, 18'h00108, 0, 18'h0AAAA, st, rq, we, wr);
        check("b2b2_stall", st, 0);
        check("b2b2_rdata", ReadDataW, 18'h0AAAA);
        check("b2b2_rd", RdW, 2);
        check("b2b2_pc", PCPlus4W, 18'h00108);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
